// File: rtl/feedback_sequencer.sv
// -----------------------------------------------------------------------------
// feedback_sequencer
//
// Schedules the game's feedback patterns. One-cycle game event pulses are
// latched into a pending vector, arbitrated by fixed priority and handed to
// the pattern player one at a time. The block drives the player's pattern
// select, start pulse and step tick, and waits for the player's done flag.
// Every pattern is bounded by a step-count timeout and followed by a silent
// gap of GAP_TICKS step ticks before the next pattern may start.
//
// Parameters
//   TICK_DIV       clk cycles per step_tick (>= 2)
//   GAP_TICKS      step ticks of silence after each pattern (>= 1)
//   TIMEOUT_TICKS  step ticks allowed in PLAY before the pattern is aborted (>= 1)
//
// Ports
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset
//   game_win            event pulse, priority 0 (highest), terminal
//   alphabet_found      event pulse, priority 1
//   alphabet_not_found  event pulse, priority 2
//   game_over           event pulse, priority 3 (lowest), terminal
//   play_done           player finished the current pattern (level or pulse)
//   play_start          one-cycle start pulse to the player
//   play_sel            pattern code: 00 win, 01 found, 10 not_found, 11 over
//   step_tick           one-cycle step pulse every TICK_DIV cycles
//   busy                high while a pattern plays or its gap runs
//   pending             latched requests {over, not_found, found, win}
//   dropped             one-cycle pulse: event merged into an already-set bit
//   timeout             one-cycle pulse: pattern aborted by the step timeout
// -----------------------------------------------------------------------------
module feedback_sequencer #(
  parameter int TICK_DIV      = 5000000,
  parameter int GAP_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_win,
  input  logic       alphabet_found,
  input  logic       alphabet_not_found,
  input  logic       game_over,
  input  logic       play_done,
  output logic       play_start,
  output logic [1:0] play_sel,
  output logic       step_tick,
  output logic       busy,
  output logic [3:0] pending,
  output logic       dropped,
  output logic       timeout
);

  // ---------------------------------------------------------------------------
  // Counter widths and terminal values
  // ---------------------------------------------------------------------------
  localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int STEP_W = $clog2(TIMEOUT_TICKS + 1);
  localparam int GAP_W  = $clog2(GAP_TICKS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(TIMEOUT_TICKS - 1);
  localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(TIMEOUT_TICKS);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_TICKS - 1);
  localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(GAP_TICKS);

  // Bits that survive a terminal event (win and over); found/not_found are
  // meaningless once the game has ended.
  localparam logic [3:0] TERMINAL_MASK = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e            state_q,      state_d;
  logic [3:0]        pending_q,    pending_d;
  logic [1:0]        play_sel_q,   play_sel_d;
  logic              play_start_q, play_start_d;
  logic              busy_q,       busy_d;
  logic              dropped_q,    dropped_d;
  logic              timeout_q,    timeout_d;
  logic              step_tick_q,  step_tick_d;
  logic [DIV_W-1:0]  div_q,        div_d;
  logic [STEP_W-1:0] step_cnt_q,   step_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q,    gap_cnt_d;

  // ---------------------------------------------------------------------------
  // Arbitration helpers
  // ---------------------------------------------------------------------------
  logic [3:0] events;
  logic       flush;
  logic [3:0] events_acc;
  logic       grant_en;
  logic [3:0] grant_oh;
  logic [1:0] grant_code;
  logic [3:0] pending_keep;

  assign events = {game_over, alphabet_not_found, alphabet_found, game_win};
  assign flush  = game_win | game_over;

  // Only IDLE grants; the lowest set index has the highest priority.
  assign grant_en = (state_q == ST_IDLE) && (pending_q != 4'b0000);

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    grant_oh   = 4'b0000;
    grant_code = 2'b00;
    if (pending_q[0]) begin
      grant_oh   = 4'b0001;
      grant_code = 2'b00;
    end else if (pending_q[1]) begin
      grant_oh   = 4'b0010;
      grant_code = 2'b01;
    end else if (pending_q[2]) begin
      grant_oh   = 4'b0100;
      grant_code = 2'b10;
    end else if (pending_q[3]) begin
      grant_oh   = 4'b1000;
      grant_code = 2'b11;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending latch
  // ---------------------------------------------------------------------------
  // The granted bit is removed before new events are merged, so an event for
  // the same bit at the grant edge re-sets it as a fresh request instead of
  // being reported as dropped. A terminal event clears found/not_found and
  // swallows a found/not_found arriving at the same edge without a drop.
  always_comb begin
    events_acc   = flush ? (events & TERMINAL_MASK) : events;
    pending_keep = pending_q;
    if (grant_en) begin
      pending_keep = pending_keep & ~grant_oh;
    end
    if (flush) begin
      pending_keep = pending_keep & TERMINAL_MASK;
    end
    pending_d = pending_keep | events_acc;
    dropped_d = |(pending_keep & events_acc);
  end

  // ---------------------------------------------------------------------------
  // Step tick divider
  // ---------------------------------------------------------------------------
  // Free-running, but restarted on the grant edge so the pattern's first step
  // lands a full period after play_start. The tick flop is loaded from the
  // next count, so step_tick is high exactly while div_q sits at its last value.
  always_comb begin
    if (grant_en || (div_q == DIV_LAST)) begin
      div_d = '0;
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    step_tick_d = (div_d == DIV_LAST);
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM: next state, counters and pulse outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    play_sel_d   = play_sel_q;
    play_start_d = 1'b0;
    timeout_d    = 1'b0;
    step_cnt_d   = step_cnt_q;
    gap_cnt_d    = gap_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        step_cnt_d = '0;
        gap_cnt_d  = '0;
        if (grant_en) begin
          state_d      = ST_PLAY;
          play_sel_d   = grant_code;
          play_start_d = 1'b1;
        end
      end

      ST_PLAY: begin
        // play_done is ignored in the start cycle: the player may still be
        // showing done from the previous pattern. Done outranks the final
        // tick, so a pattern finishing on time never reports a timeout.
        if (!play_start_q && play_done) begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end else if (step_tick_q) begin
          if (step_cnt_q >= STEP_LAST) begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
            timeout_d = 1'b1;
          end else if (step_cnt_q != STEP_MAX) begin
            step_cnt_d = step_cnt_q + STEP_W'(1);
          end
        end
      end

      ST_GAP: begin
        if (step_tick_q) begin
          if (gap_cnt_q >= GAP_LAST) begin
            state_d = ST_IDLE;
          end else if (gap_cnt_q != GAP_MAX) begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  // NOTE: every flop here, including all counters, is reset: a reset mid-pattern
  // must abandon the pattern and discard all pending requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= 4'b0000;
      play_sel_q   <= 2'b00;
      play_start_q <= 1'b0;
      busy_q       <= 1'b0;
      dropped_q    <= 1'b0;
      timeout_q    <= 1'b0;
      step_tick_q  <= 1'b0;
      div_q        <= '0;
      step_cnt_q   <= '0;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      play_sel_q   <= play_sel_d;
      play_start_q <= play_start_d;
      busy_q       <= busy_d;
      dropped_q    <= dropped_d;
      timeout_q    <= timeout_d;
      step_tick_q  <= step_tick_d;
      div_q        <= div_d;
      step_cnt_q   <= step_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  assign play_start = play_start_q;
  assign play_sel   = play_sel_q;
  assign step_tick  = step_tick_q;
  assign busy       = busy_q;
  assign pending    = pending_q;
  assign dropped    = dropped_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_feedback_sequencer.sv
// -----------------------------------------------------------------------------
// tb_feedback_sequencer
//
// Self-checking bench for feedback_sequencer with TICK_DIV=4, GAP_TICKS=2,
// TIMEOUT_TICKS=8. Expected pattern codes are queued when the triggering
// events are driven and compared against play_sel on every play_start.
// Inputs change 1 time unit after a rising edge; outputs are read at the same
// point (values of the new cycle) or on the falling edge by the monitor.
// -----------------------------------------------------------------------------
module tb_feedback_sequencer;

  localparam int TICK_DIV      = 4;
  localparam int GAP_TICKS     = 2;
  localparam int TIMEOUT_TICKS = 8;

  logic       clk;
  logic       rst_n;
  logic       game_win;
  logic       alphabet_found;
  logic       alphabet_not_found;
  logic       game_over;
  logic       play_done;
  logic       play_start;
  logic [1:0] play_sel;
  logic       step_tick;
  logic       busy;
  logic [3:0] pending;
  logic       dropped;
  logic       timeout;

  feedback_sequencer #(
    .TICK_DIV      (TICK_DIV),
    .GAP_TICKS     (GAP_TICKS),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .game_win           (game_win),
    .alphabet_found     (alphabet_found),
    .alphabet_not_found (alphabet_not_found),
    .game_over          (game_over),
    .play_done          (play_done),
    .play_start         (play_start),
    .play_sel           (play_sel),
    .step_tick          (step_tick),
    .busy               (busy),
    .pending            (pending),
    .dropped            (dropped),
    .timeout            (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int n_starts  = 0;
  int n_dropped = 0;
  int n_timeout = 0;

  logic [1:0] exp_q[$];
  logic [1:0] exp_sel;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard side: every start must match the oldest queued pattern code.
  always @(negedge clk) begin
    if (play_start === 1'b1) begin
      n_starts++;
      if (exp_q.size() == 0) begin
        check("unexpected_start", 32'(play_sel), 32'hFFFF);
      end else begin
        exp_sel = exp_q.pop_front();
        check("play_sel", 32'(play_sel), 32'(exp_sel));
      end
    end
    if (dropped === 1'b1) n_dropped++;
    if (timeout === 1'b1) n_timeout++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive events {over, not_found, found, win} for one sampling edge.
  task automatic pulse(input logic [3:0] ev);
    {game_over, alphabet_not_found, alphabet_found, game_win} = ev;
    tick();
    {game_over, alphabet_not_found, alphabet_found, game_win} = 4'b0000;
  endtask

  // Returns in the play_start cycle, with its cycle number.
  task automatic wait_start(input string tag, output int at);
    int n = 0;
    while (play_start !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(play_start), 32'd1);
    at = cyc;
  endtask

  task automatic finish_after(input int n, output int done_at);
    repeat (n) tick();
    play_done = 1'b1;
    done_at   = cyc;
    tick();
    play_done = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_pending"},    32'(pending),    32'h0);
    check({tag, "_play_start"}, 32'(play_start), 32'h0);
    check({tag, "_play_sel"},   32'(play_sel),   32'h0);
    check({tag, "_busy"},       32'(busy),       32'h0);
    check({tag, "_step_tick"},  32'(step_tick),  32'h0);
    check({tag, "_dropped"},    32'(dropped),    32'h0);
    check({tag, "_timeout"},    32'(timeout),    32'h0);
  endtask

  int s, d, n, base_st, base_dr, base_to;

  initial begin
    rst_n = 1'b0;
    {game_over, alphabet_not_found, alphabet_found, game_win} = 4'b0000;
    play_done = 1'b0;

    // ---- reset state ----
    repeat (3) tick();
    check_quiet("reset");
    rst_n = 1'b1;
    repeat (3) tick();

    // ---- single event ----
    pulse(4'b0010);
    exp_q.push_back(2'b01);
    check("single_pending", 32'(pending), 32'h2);
    check("single_no_start_yet", 32'(play_start), 32'd0);
    tick();
    check("single_start", 32'(play_start), 32'd1);
    check("single_busy", 32'(busy), 32'd1);
    check("single_sel", 32'(play_sel), 32'h1);
    check("single_pending_clr", 32'(pending), 32'h0);
    repeat (2) tick();
    check("tick_low_s2", 32'(step_tick), 32'd0);
    tick();
    check("tick_high_s3", 32'(step_tick), 32'd1);
    play_done = 1'b1;
    tick();
    play_done = 1'b0;
    check("single_gap_busy", 32'(busy), 32'd1);
    wait_idle("single_idle", n);
    check("single_gap_len", 32'(n), 32'd8);
    tick();
    check("single_one_start", 32'(n_starts), 32'd1);

    // ---- priority: over then not_found queued behind a running win ----
    base_dr = n_dropped;
    pulse(4'b0001);
    exp_q.push_back(2'b00);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b11);
    wait_start("prio_start_win", s);
    pulse(4'b1000);
    pulse(4'b0100);
    check("prio_pending", 32'(pending), 32'hC);
    finish_after(1, d);
    wait_start("prio_start_nf", s);
    check("prio_gap_cycles", 32'(s - d), 32'd10);
    finish_after(3, d);
    wait_start("prio_start_over", s);
    check("prio_gap2_cycles", 32'(s - d), 32'd10);
    finish_after(3, d);
    wait_idle("prio_idle", n);
    tick();
    check("prio_starts", 32'(n_starts), 32'd4);
    check("prio_no_drop", 32'(n_dropped - base_dr), 32'd0);

    // ---- terminal flush ----
    base_st = n_starts;
    base_dr = n_dropped;
    pulse(4'b0100);
    exp_q.push_back(2'b10);
    wait_start("flush_start_nf", s);
    pulse(4'b0010);
    check("flush_found_pending", 32'(pending), 32'h2);
    pulse(4'b0011);
    exp_q.push_back(2'b00);
    check("flush_pending", 32'(pending), 32'h1);
    check("flush_dropped", 32'(dropped), 32'd0);
    finish_after(1, d);
    wait_start("flush_start_win", s);
    finish_after(3, d);
    wait_idle("flush_idle", n);
    repeat (6) tick();
    check("flush_starts", 32'(n_starts - base_st), 32'd2);
    check("flush_no_drop", 32'(n_dropped - base_dr), 32'd0);

    // ---- coalesce ----
    base_st = n_starts;
    base_dr = n_dropped;
    pulse(4'b0001);
    exp_q.push_back(2'b00);
    wait_start("coal_start_win", s);
    pulse(4'b0100);
    check("coal_pending1", 32'(pending), 32'h4);
    check("coal_no_drop1", 32'(dropped), 32'd0);
    pulse(4'b0100);
    exp_q.push_back(2'b10);
    check("coal_pending2", 32'(pending), 32'h4);
    check("coal_drop2", 32'(dropped), 32'd1);
    finish_after(1, d);
    wait_start("coal_start_nf", s);
    finish_after(3, d);
    wait_idle("coal_idle", n);
    repeat (6) tick();
    check("coal_drops", 32'(n_dropped - base_dr), 32'd1);
    check("coal_starts", 32'(n_starts - base_st), 32'd2);

    // ---- timeout ----
    base_st = n_starts;
    base_to = n_timeout;
    pulse(4'b1000);
    exp_q.push_back(2'b11);
    wait_start("to_start", s);
    n = 0;
    while (timeout !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("to_delay", 32'(n), 32'd32);
    check("to_busy", 32'(busy), 32'd1);
    wait_idle("to_idle", n);
    check("to_gap_len", 32'(n), 32'd8);
    repeat (10) tick();
    check("to_no_replay", 32'(n_starts - base_st), 32'd1);
    check("to_count", 32'(n_timeout - base_to), 32'd1);

    // ---- done coincides with the final tick ----
    base_to = n_timeout;
    pulse(4'b0001);
    exp_q.push_back(2'b00);
    wait_start("tod_start", s);
    repeat (31) tick();
    check("tod_tick8", 32'(step_tick), 32'd1);
    play_done = 1'b1;
    tick();
    play_done = 1'b0;
    check("tod_timeout", 32'(timeout), 32'd0);
    check("tod_busy", 32'(busy), 32'd1);
    wait_idle("tod_idle", n);
    check("tod_gap_len", 32'(n), 32'd8);
    tick();
    check("tod_no_timeout", 32'(n_timeout - base_to), 32'd0);

    // ---- reset mid-PLAY ----
    base_st = n_starts;
    pulse(4'b0001);
    exp_q.push_back(2'b00);
    wait_start("rst_start", s);
    pulse(4'b1000);
    check("rst_pending_pre", 32'(pending), 32'h8);
    rst_n = 1'b0;
    #1;
    check_quiet("rst_async");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("rst_pending_post", 32'(pending), 32'h0);
    check("rst_no_start", 32'(n_starts - base_st), 32'd1);
    pulse(4'b0010);
    exp_q.push_back(2'b01);
    wait_start("rst_new_start", s);
    finish_after(3, d);
    wait_idle("rst_idle", n);
    tick();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/feedback_sequencer.md
# feedback_sequencer

Schedules the game's feedback patterns: latches one-cycle game event pulses, arbitrates them by fixed priority, and starts the pattern player for one pattern at a time. It drives the player's pattern select, start pulse and step tick, and waits for the player's done flag. A step-count timeout and an inter-pattern gap bound every pattern. Sits between the game-logic FSM (event source) and the pattern/address player.

## Interface
- TICK_DIV, 5000000: clk cycles per step_tick (≥2)
- GAP_TICKS, 2: step ticks of silence enforced after each pattern (≥1)
- TIMEOUT_TICKS, 8: step ticks allowed in PLAY before abort (≥1)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- game_win  in  1  event pulse, priority 0 (highest)
- alphabet_found  in  1  event pulse, priority 1
- alphabet_not_found  in  1  event pulse, priority 2
- game_over  in  1  event pulse, priority 3 (lowest)
- play_done  in  1  player finished current pattern (level or pulse)
- play_start  out  1  one-cycle start pulse to player
- play_sel  out  2  pattern code: 00 win, 01 found, 10 not_found, 11 over
- step_tick  out  1  one-cycle step pulse every TICK_DIV cycles
- busy  out  1  high in PLAY and GAP
- pending  out  4  {over, not_found, found, win} latched requests
- dropped  out  1  one-cycle pulse: event coalesced into an already-set pending bit
- timeout  out  1  one-cycle pulse: pattern aborted by timeout

## Operation
- Pending latch: an event high at edge k sets its pending bit from cycle k+1. If the bit is already set, it stays set and dropped pulses.
- Terminal flush: game_win or game_over sampled high clears pending found and not_found at the same edge. A found/not_found arriving in that same edge is discarded; dropped is not asserted for it.
- Simultaneous events: all latch independently, subject to the flush.
- FSM states are IDLE, PLAY and GAP.
- IDLE → PLAY at any edge where pending≠0.
  - The highest-priority set bit is granted and cleared.
  - play_sel is loaded with the granted code.
  - play_start is high for the first PLAY cycle.
  - The tick counter is cleared.
- Grant/event collision: an event for the same bit sampled at the grant edge re-sets the bit. That counts as a new request, so dropped stays low.
- PLAY
  - play_done is ignored in the play_start cycle.
  - From the next cycle, play_done high → GAP.
  - Otherwise, when the TIMEOUT_TICKS-th step_tick since start occurs → timeout pulse, GAP.
  - If done and the final tick coincide, done wins and timeout stays low.
- GAP
  - Counts GAP_TICKS step_ticks, then → IDLE.
  - play_sel holds its last value.
- Events are accepted in every state; only IDLE grants.
- Tick divider
  - Free-running counter, 0..TICK_DIV-1. step_tick is high while the count equals TICK_DIV-1.
  - Counter forced to 0 on the IDLE→PLAY edge, so the first tick is TICK_DIV cycles after play_start.
  - Width $clog2(TICK_DIV).
- Step and gap counters are $clog2(max+1) wide and saturate; they never wrap.

## Timing
- Reset (async assert, synchronous release on the next edge): state IDLE, pending=0, play_sel=00, play_start=0, step_tick=0, busy=0, dropped=0, timeout=0, all counters 0.
- Reset mid-PLAY or mid-GAP abandons the pattern and discards all pending requests.
- Latency from an event at edge k with the FSM in IDLE:
  - pending visible in cycle k+1;
  - play_start and busy high in cycle k+2.
- busy drops in the cycle after the last GAP tick. The earliest next play_start follows one IDLE cycle later.
- All outputs are registered.

## Test plan
(TICK_DIV=4, GAP_TICKS=2, TIMEOUT_TICKS=8)
- Single event: alphabet_found pulse at edge 10, play_done 3 cycles after start.
  - Expect pending=0010 in cycle 11, play_start with play_sel=01 in cycle 12.
  - Expect busy low again 8 cycles after done plus one.
- Priority: alphabet_not_found and game_over in the same cycle → pending=1100; patterns played as 10 then 11, with a ≥8-cycle gap between them.
- Terminal flush: found pending during PLAY, then game_win arrives → pending becomes 0001; found is never played.
- Coalesce: two alphabet_not_found pulses while PLAY is busy → a single dropped pulse; exactly one 10 pattern follows.
- Timeout: never assert play_done → timeout pulse on the 8th tick, 32 cycles after start; pattern is not replayed. A variant with done on the same edge as that tick gives no timeout pulse.
- Reset: assert rst_n low mid-PLAY with pending=1000 → all outputs and pending are 0 immediately; no play_start after release until a new event.
